wb_line_memory_slave: RTL
=========================

Name: wb_line_memory_slave

Overview:
- Wishbone slave/responder that terminates the L2-side master port of the cache interconnect.
- Services single-line (128-bit) read and write cycles against an internal line-addressed memory.
- Response latency is programmable, and the RTY path is exercised on out-of-range addresses.
- Serves as the memory-side responder for the interconnect and caches in simulation, and as a synthesizable backing store.

Parameters:
- LATENCY, 4: cycles from request acceptance to ACK/RTY; legal range 1..15.
- DEPTH, 256: number of 128-bit lines implemented; legal range 1..4096.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- CYC  in  1  bus cycle valid from master.
- STB  in  1  strobe from master.
- WE  in  1  1 = write, 0 = read.
- SEL  in  16  byte enables; bit i covers DAT_M[8i+7:8i].
- ADR  in  12  line address.
- DAT_M  in  128  write data from master.
- DAT_S  out  128  read data to master.
- ACK  out  1  normal termination, one-cycle pulse.
- RTY  out  1  retry termination, one-cycle pulse.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - state=IDLE, counter=0, ACK=0, RTY=0, DAT_S=0.
  - Memory contents are not reset; they keep their value across reset and are X in simulation until first written.
- All outputs are registered. DAT_S is 0 in every cycle where ACK is not high.
- State machine has three states: IDLE, BUSY, RESPOND.
- IDLE:
  - "Cycle 0" is the cycle in which CYC&STB is sampled high while in IDLE; that request is accepted.
  - On acceptance, latch WE, SEL, ADR and DAT_M. Later changes on these inputs are ignored until the next acceptance.
  - If LATENCY==1, go to RESPOND; otherwise go to BUSY with counter=LATENCY-2.
- BUSY:
  - If CYC is sampled 0, abort: return to IDLE with no ACK, no RTY and no memory write.
  - Otherwise, if counter==0, go to RESPOND; else decrement the counter.
- RESPOND (exactly cycle LATENCY relative to cycle 0):
  - If latched ADR < DAT range (ADR<DEPTH):
    - ACK=1.
    - Read: DAT_S = mem[ADR].
    - Write: DAT_S=0; at the closing edge of this cycle, bytes with SEL[i]=1 are written and bytes with SEL=0 keep their old value.
  - If ADR >= DEPTH: RTY=1, ACK=0, DAT_S=0, no memory access.
  - The response is given even if CYC drops during the RESPOND cycle.
  - Next state is IDLE unconditionally.
- Back-to-back requests: the earliest next acceptance is the cycle after RESPOND, when the slave is in IDLE. A request held high through that cycle is treated as a new request.
- Read-after-write: a read accepted any time after a write's ACK cycle returns the merged write data.
- ACK and RTY are never high together. Neither output is high for more than one consecutive cycle.
- Reset asserted mid-transaction (BUSY or RESPOND) clears state and outputs immediately. A write whose RESPOND cycle is cut by reset is not committed.
- CYC=1 with STB=0 in IDLE is ignored.
- WE, SEL and DAT_M are don't-care on reads.
- SEL=0 on a write still ACKs and leaves memory unchanged.

Test Plan:
- Reset then write, LATENCY=4: write ADR=0x005, SEL=0xFFFF, DAT_M=0x0123..CDEF, accepted in cycle 0.
  - Required: ACK high only in cycle 4, DAT_S=0.
  - A subsequent read of 0x005 ACKs in cycle 4 of its own transaction with DAT_S=0x0123..CDEF.
- Partial write: initialize 0x010 to all 0xAA bytes, then write SEL=0x000F, DAT_M=all 0x55.
  - Required: a read returns 0xAAAA..AAAA_55555555 (low 4 bytes 0x55, rest 0xAA).
- Out of range, DEPTH=256: read ADR=0x100.
  - Required: RTY=1 in cycle 4, ACK never high, DAT_S=0.
  - A write to 0x100 also returns RTY; reading 0x000..0x0FF afterwards shows no change.
- Abort: read ADR=0x003 accepted, then CYC dropped in cycle 2.
  - Required: no ACK or RTY in cycles 0-8; the next request in cycle 5 ACKs in cycle 9.
- Back-to-back, LATENCY=1: CYC/STB held high continuously, ADR changing to 0x001, 0x002, 0x003.
  - Required: ACKs in cycles 1, 3, 5 with the matching data; ACK never high in two consecutive cycles.
- Async reset mid-write: drop rst_n during cycle 2 of a write to 0x007 (prior value 0x11..11), release it, then read 0x007.
  - Required: ACK, RTY and DAT_S go 0 immediately, without waiting for a clock edge.
  - The read returns 0x11..11.

Source files
------------

// File: rtl/wb_line_memory_slave_if.sv
// Wishbone line bus between the L2-side master port and the memory responder.
// One 128-bit line per cycle; SEL gives per-byte write enables.
interface wb_line_memory_slave_if;
    logic         CYC;
    logic         STB;
    logic         WE;
    logic [15:0]  SEL;
    logic [11:0]  ADR;
    logic [127:0] DAT_M;
    logic [127:0] DAT_S;
    logic         ACK;
    logic         RTY;

    modport master (
        output CYC, STB, WE, SEL, ADR, DAT_M,
        input  DAT_S, ACK, RTY
    );

    modport slave (
        input  CYC, STB, WE, SEL, ADR, DAT_M,
        output DAT_S, ACK, RTY
    );
endinterface

// File: rtl/wb_line_memory_slave.sv
// Wishbone line-memory responder with programmable ACK/RTY latency.
// Out-of-range line addresses terminate with RTY and never touch memory.
module wb_line_memory_slave #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 256
) (
    input logic                  clk,
    input logic                  rst_n,
    wb_line_memory_slave_if.slave bus
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LINES = 1 << AW;
    localparam logic [3:0] CNT_INIT =
        (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND
    } state_e;

    state_e         state_q;
    logic [3:0]     cnt_q;
    logic           we_q;
    logic [15:0]    sel_q;
    logic [11:0]    adr_q;
    logic [127:0]   dat_q;
    logic           ack_q;
    logic           rty_q;
    logic [127:0]   dats_q;

    logic [127:0]   mem [LINES];

    logic           req;
    logic           go_rsp;
    logic [11:0]    rsp_adr;
    logic           rsp_we;
    logic           rsp_hit;
    logic [127:0]   rd_line;

    // With LATENCY==1 the response is decided from the live bus inputs.
    always_comb begin
        req     = bus.CYC && bus.STB;
        rsp_adr = (state_q == IDLE) ? bus.ADR : adr_q;
        rsp_we  = (state_q == IDLE) ? bus.WE  : we_q;
        rsp_hit = {1'b0, rsp_adr} < 13'(DEPTH);
        rd_line = mem[rsp_adr[AW-1:0]];
        go_rsp  = 1'b0;
        if (state_q == IDLE && req && LATENCY == 1)
            go_rsp = 1'b1;
        if (state_q == BUSY && bus.CYC && cnt_q == 4'd0)
            go_rsp = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            rty_q   <= 1'b0;
            dats_q  <= '0;
        end else begin
            ack_q  <= 1'b0;
            rty_q  <= 1'b0;
            dats_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q  <= bus.WE;
                        sel_q <= bus.SEL;
                        adr_q <= bus.ADR;
                        dat_q <= bus.DAT_M;
                        cnt_q <= CNT_INIT;
                        state_q <= (LATENCY == 1) ? RESPOND : BUSY;
                    end
                end
                BUSY: begin
                    if (!bus.CYC)
                        state_q <= IDLE;
                    else if (cnt_q == 4'd0)
                        state_q <= RESPOND;
                    else
                        cnt_q <= cnt_q - 4'd1;
                end
                RESPOND: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (go_rsp) begin
                ack_q <= rsp_hit;
                rty_q <= !rsp_hit;
                if (rsp_hit && !rsp_we)
                    dats_q <= rd_line;
            end
        end
    end

    // Commit on the edge closing RESPOND; a reset in RESPOND drops it.
    always_ff @(posedge clk) begin
        if (state_q == RESPOND && ack_q && we_q) begin
            for (int i = 0; i < 16; i++) begin
                if (sel_q[i])
                    mem[adr_q[AW-1:0]][8*i +: 8] <= dat_q[8*i +: 8];
            end
        end
    end

    assign bus.ACK   = ack_q;
    assign bus.RTY   = rty_q;
    assign bus.DAT_S = dats_q;

endmodule
